// File: rtl/if_pc_gen_pkg.sv
// if_pc_gen_pkg: shared hold codes, reset address and fetch FSM encoding for the PC generator
package if_pc_gen_pkg;

    localparam int          INST_ADDR_BUS = 32;
    localparam logic [31:0] RESET_ADDR    = 32'h0000_0000;

    localparam logic [2:0] HOLD_NONE  = 3'b000;
    localparam logic [2:0] HOLD_PC    = 3'b001;
    localparam logic [2:0] HOLD_IF_ID = 3'b010;
    localparam logic [2:0] HOLD_ID_EX = 3'b011;

    typedef enum logic [1:0] {
        FETCH_BOOT = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_pc_gen.sv
// if_pc_gen: fetch-address generator owning the program counter ahead of the IF/ID register
//   clk, rst_n      : clock, synchronous active-low reset
//   hold_flag_i     : pipeline hold code from ctrl
//   jump_flag_i/jump_addr_i : single-cycle redirect from EX and its byte target
//   halt_req_i      : debug halt request (level); halted_o reports the frozen fetch
//   ibus_req_o/ibus_gnt_i   : instruction bus request and grant
//   pc_o            : registered fetch address to ROM and IF/ID
//   fetch_valid_o   : ROM data seen this cycle belongs to a valid fetch
//   misalign_o      : one-cycle pulse when a redirect target was not word aligned
module if_pc_gen
    import if_pc_gen_pkg::*;
#(
    parameter logic [INST_ADDR_BUS-1:0] RESET_PC = RESET_ADDR,
    parameter logic [INST_ADDR_BUS-1:0] PC_STEP  = 32'd4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2:0]               hold_flag_i,
    input  logic                     jump_flag_i,
    input  logic [INST_ADDR_BUS-1:0] jump_addr_i,
    input  logic                     halt_req_i,
    output logic                     halted_o,
    output logic                     ibus_req_o,
    input  logic                     ibus_gnt_i,
    output logic [INST_ADDR_BUS-1:0] pc_o,
    output logic                     fetch_valid_o,
    output logic                     misalign_o
);

    fetch_state_e             state_q, state_d;
    logic [INST_ADDR_BUS-1:0] pc_q, pc_d;
    logic                     fv_q, fv_d;
    logic                     mis_q, mis_d;
    logic [INST_ADDR_BUS-1:0] jump_tgt;

    assign jump_tgt = {jump_addr_i[INST_ADDR_BUS-1:2], 2'b00};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fv_d    = 1'b0;
        mis_d   = 1'b0;
        case (state_q)
            FETCH_BOOT: state_d = FETCH_RUN;
            FETCH_RUN: begin
                // data for this cycle's address arrives next cycle; flag it only if the fetch survives
                fv_d = ibus_gnt_i & ~jump_flag_i & ~halt_req_i & (hold_flag_i < HOLD_PC);
                if (jump_flag_i) begin
                    pc_d  = jump_tgt;
                    mis_d = |jump_addr_i[1:0];
                end else if (halt_req_i) begin
                    state_d = FETCH_HALT;
                end else if (hold_flag_i < HOLD_PC && ibus_gnt_i) begin
                    pc_d = pc_q + PC_STEP;
                end
            end
            FETCH_HALT: begin
                // a redirect retiring while halted must still land so resume starts at the target
                if (jump_flag_i) begin
                    pc_d  = jump_tgt;
                    mis_d = |jump_addr_i[1:0];
                end
                if (!halt_req_i) state_d = FETCH_RUN;
            end
            default: state_d = FETCH_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH_BOOT;
            pc_q    <= RESET_PC;
            fv_q    <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fv_q    <= fv_d;
            mis_q   <= mis_d;
        end
    end

    assign pc_o          = pc_q;
    assign ibus_req_o    = (state_q == FETCH_RUN);
    assign halted_o      = (state_q == FETCH_HALT);
    assign fetch_valid_o = fv_q;
    assign misalign_o    = mis_q;

endmodule
